dot_product_ctrl: RTL
=====================

DOT_PRODUCT_CTRL -- requirements
Module: dot_product_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: max WAIT-state cycles before abort (range 16..65535).
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic bus-slave handshake qualifiers.
REQ-005 wb_adr  in  6  word address; wb_dat_w  in  32  write data; wb_dat_r  out  32  read data; wb_ack  out  1  transfer acknowledge.
REQ-006 acc_start  out  1  start pulse to the accelerator; acc_done  in  1  accelerator done level.
REQ-007 acc_a, acc_b  out  256 each  packed operands, element i at bits [32i+31:32i]; acc_result  in  64  signed result.
REQ-008 irq  out  1  level interrupt, present only per REQ-028.

Function
REQ-009 Register map (word addr): 0x00-0x07 A0-A7 RW; 0x08-0x0F B0-B7 RW; 0x10 CTRL; 0x11 STATUS; 0x12 RESULT_LO RO; 0x13 RESULT_HI RO; 0x14 CYCLES RO.
REQ-010 CTRL: bit0 write-1 = start request (self-clearing, reads 0); bit1 irq_en RW.
REQ-011 STATUS: bit0 busy RO; bit1 done and bit2 timeout are sticky, write-1-to-clear.
REQ-012 Unmapped addresses: read 0, writes ignored, still acknowledged.
REQ-013 wb_ack asserts for exactly one cycle, the cycle after wb_cyc&wb_stb is sampled high with wb_ack low; wb_dat_r is registered and valid with wb_ack.
REQ-014 acc_a/acc_b are driven continuously from A0-A7/B0-B7.
REQ-015 FSM states IDLE, LAUNCH, WAIT; busy=1 in LAUNCH and WAIT.
REQ-016 IDLE -> LAUNCH on start request; simultaneously clear done, timeout and CYCLES.
REQ-017 LAUNCH: acc_start=1 for exactly this one cycle; -> WAIT.
REQ-018 WAIT: CYCLES increments every cycle; acc_done is ignored in the first WAIT cycle.
REQ-019 WAIT, acc_done=1 (from second cycle): RESULT <= acc_result, done <= 1, -> IDLE.
REQ-020 WAIT, CYCLES reaches TIMEOUT_CYCLES without done: timeout <= 1, RESULT unchanged, -> IDLE.
REQ-021 While busy: writes to A/B and start requests are acknowledged but ignored.
REQ-022 Write-1-clear of done in the same cycle as completion: completion wins, done stays 1.
REQ-023 CYCLES saturates at 0xFFFF; upper 16 bits of the CYCLES read are 0.

Reset
REQ-024 On rst: FSM=IDLE; acc_start, wb_ack, irq = 0; wb_dat_r = 0.
REQ-025 On rst: A0-A7, B0-B7, RESULT, CYCLES = 0; done, timeout, irq_en = 0.
REQ-026 rst mid-WAIT aborts the operation; any later acc_done is ignored until a new start.
REQ-027 A bus transfer in flight at rst is not acknowledged; the master reissues it.

Configuration
REQ-028 DOT_PRODUCT_CTRL_IRQ_EN defined: irq = irq_en & (done | timeout), registered; undefined: irq tied 0, CTRL bit1 reads 0 and writes are ignored.

Verification
REQ-029 A=1..8, B=1..8, start -> acc_start single pulse; done=1; RESULT_LO=204, RESULT_HI=0; CYCLES=9 with the 8-element sequential accelerator.
REQ-030 A all 0xFFFFFFFF, B all 2 -> RESULT_LO=0xFFFFFFF0, RESULT_HI=0xFFFFFFFF.
REQ-031 Stubbed acc_done=0, TIMEOUT_CYCLES=64 -> STATUS=0b100 after 64 WAIT cycles; RESULT keeps its prior value.
REQ-032 Write A0=99 and a second start while busy -> A0 keeps its old value; only one acc_start pulse; result matches the original operands.
REQ-033 rst asserted 3 cycles into WAIT, acc_done later pulses -> STATUS=0, RESULT=0, no irq.
REQ-034 Macro defined, irq_en=1, completion -> irq=1; write STATUS bit1=1 -> irq=0 on the next cycle.

Source files
------------

// File: rtl/dot_product_ctrl.sv
// Dot-product accelerator controller: Wishbone classic register file plus launch/wait/timeout FSM.
// Define DOT_PRODUCT_CTRL_IRQ_EN to build the level interrupt and the CTRL irq_en bit.
module dot_product_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wb_cyc,
    input  logic         wb_stb,
    input  logic         wb_we,
    input  logic [5:0]   wb_adr,
    input  logic [31:0]  wb_dat_w,
    output logic [31:0]  wb_dat_r,
    output logic         wb_ack,
    output logic         acc_start,
    input  logic         acc_done,
    output logic [255:0] acc_a,
    output logic [255:0] acc_b,
    input  logic [63:0]  acc_result,
    output logic         irq
);
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLaunch = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;

    localparam logic [5:0] AdrCtrl   = 6'h10;
    localparam logic [5:0] AdrStatus = 6'h11;
    localparam logic [5:0] AdrResLo  = 6'h12;
    localparam logic [5:0] AdrResHi  = 6'h13;
    localparam logic [5:0] AdrCycles = 6'h14;

    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [7:0][31:0]  a_q, a_d;
    logic [7:0][31:0]  b_q, b_d;
    logic [63:0]       result_q, result_d;
    logic [15:0]       cycles_q, cycles_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              ack_q;
    logic [31:0]       dat_r_q, dat_r_d;
    logic [31:0]       rd_data;
    logic              busy, bus_req, bus_wr, start_req;
    logic              irq_en_rd;

    assign busy      = (state_q != StIdle);
    // A new transfer is only taken while no ack is outstanding, giving single-cycle acks.
    assign bus_req   = wb_cyc & wb_stb & ~ack_q;
    assign bus_wr    = bus_req & wb_we;
    assign start_req = bus_wr && (wb_adr == AdrCtrl) && wb_dat_w[0];

    assign acc_a     = a_q;
    assign acc_b     = b_q;
    assign acc_start = (state_q == StLaunch);
    assign wb_ack    = ack_q;
    assign wb_dat_r  = dat_r_q;

    always_comb begin
        rd_data = '0;
        if (wb_adr[5:4] == 2'b00) begin
            rd_data = wb_adr[3] ? b_q[wb_adr[2:0]] : a_q[wb_adr[2:0]];
        end else begin
            case (wb_adr)
                AdrCtrl:   rd_data = {30'd0, irq_en_rd, 1'b0};
                AdrStatus: rd_data = {29'd0, timeout_q, done_q, busy};
                AdrResLo:  rd_data = result_q[31:0];
                AdrResHi:  rd_data = result_q[63:32];
                AdrCycles: rd_data = {16'd0, cycles_q};
                default:   rd_data = '0;
            endcase
        end
        dat_r_d = (bus_req && !wb_we) ? rd_data : '0;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        done_d    = done_q;
        timeout_d = timeout_q;

        if (bus_wr) begin
            if (!busy && (wb_adr[5:4] == 2'b00)) begin
                if (wb_adr[3]) begin
                    b_d[wb_adr[2:0]] = wb_dat_w;
                end else begin
                    a_d[wb_adr[2:0]] = wb_dat_w;
                end
            end
            if (wb_adr == AdrStatus) begin
                if (wb_dat_w[1]) done_d = 1'b0;
                if (wb_dat_w[2]) timeout_d = 1'b0;
            end
        end

        // FSM updates come after the bus clears so a completion overrides a same-cycle W1C.
        case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d   = StLaunch;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
                // cycles_q is still zero in the first WAIT cycle, masking a stale done level.
                if (acc_done && (cycles_q != 16'd0)) begin
                    result_d = acc_result;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else if (cycles_d >= TimeoutVal) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            cycles_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_r_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            ack_q     <= bus_req;
            dat_r_q   <= dat_r_d;
        end
    end

`ifdef DOT_PRODUCT_CTRL_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (bus_wr && (wb_adr == AdrCtrl)) irq_en_d = wb_dat_w[1];
    end

    // Registered from next-state so irq tracks the sticky flags without extra lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_d & (done_d | timeout_d);
        end
    end

    assign irq       = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq       = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

endmodule
